// File: rtl/mem_responder_if.sv
// Processor memory bus plus boot loader stream, shared between mem_responder and its masters.
// master: the processor/host side that drives requests and loader words.
// slave: the responder side that returns read data and loader back-pressure.
interface mem_responder_if;
   logic [23:0] address_bus;
   logic [1:0]  control_bus;  // {ram_read, ram_write}
   logic [31:0] wdata_bus;
   logic [31:0] rdata_bus;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;

   modport master (
      output address_bus, control_bus, wdata_bus, load_valid, load_data, load_last,
      input  rdata_bus, load_ready
   );

   modport slave (
      input  address_bus, control_bus, wdata_bus, load_valid, load_data, load_last,
      output rdata_bus, load_ready
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-bus responder: word-addressed RAM, GPIO output register, cycle counter and a boot
// loader that holds the processor in reset while the program image is streamed in.
// Optional feature macro: MEM_RESPONDER_WRITE_PROTECT_EN -- when defined, processor writes
// to RAM indices below PROTECT_WORDS are dropped and flagged in access_error.
module mem_responder #(
   parameter int unsigned DEPTH         = 4096,
   parameter int unsigned ADDR_W        = 12,
   parameter logic [23:0] GPIO_ADDR     = 24'hFFFFF0,
   parameter logic [23:0] CYCLE_ADDR    = 24'hFFFFF4,
   parameter int unsigned PROTECT_WORDS = 256
) (
   input  logic           clk,
   input  logic           nreset,
   mem_responder_if.slave bus,
   output logic           cpu_nreset,
   output logic [31:0]    gpio_out,
   output logic           access_error
);

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
   localparam bit PROTECT_EN = 1'b1;
`else
   localparam bit PROTECT_EN = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {StLoad, StRelease, StRun} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] load_ptr_q;
   logic              cpu_nreset_q;
   logic [31:0]       gpio_q;
   logic [31:0]       cycle_q;
   logic              err_q;
   logic [31:0]       mem [DEPTH];

   logic              run;
   logic              load_acc;
   logic              ram_sel, gpio_sel, cyc_sel, unmapped, prot_hit;
   logic              rd_en, wr_en, illegal;
   logic              ram_we;
   logic              err_set;
   logic [ADDR_W-1:0] ram_idx;

   assign run      = (state_q == StRun);
   assign load_acc = bus.load_valid && (state_q == StLoad);

   // Address decode and request qualification; the bus is only honoured in RUN.
   always_comb begin
      ram_sel  = bus.address_bus < 24'(DEPTH);
      gpio_sel = bus.address_bus == GPIO_ADDR;
      cyc_sel  = bus.address_bus == CYCLE_ADDR;
      unmapped = !(ram_sel || gpio_sel || cyc_sel);
      ram_idx  = bus.address_bus[ADDR_W-1:0];
      prot_hit = PROTECT_EN && ram_sel && (bus.address_bus < 24'(PROTECT_WORDS));
      rd_en    = run && (bus.control_bus == 2'b10);
      wr_en    = run && (bus.control_bus == 2'b01);
      illegal  = run && (bus.control_bus == 2'b11);
      ram_we   = wr_en && ram_sel && !prot_hit;
      err_set  = (rd_en && unmapped) || (wr_en && (unmapped || prot_hit)) || illegal;
   end

   // Next-state logic for the boot sequence and loader back-pressure.
   always_comb begin
      state_d        = state_q;
      bus.load_ready = 1'b0;
      case (state_q)
         StLoad: begin
            bus.load_ready = 1'b1;
            // The final RAM word ends the load even without load_last, so the pointer never wraps.
            if (load_acc && (bus.load_last || (load_ptr_q == LAST_IDX))) begin
               state_d = StRelease;
            end
         end
         StRelease: state_d = StRun;
         StRun:     state_d = StRun;
         default:   state_d = StLoad;
      endcase
   end

   // State, load pointer and registered processor reset.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q      <= StLoad;
         load_ptr_q   <= '0;
         cpu_nreset_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cpu_nreset_q <= (state_d == StRun);
         if (load_acc && (load_ptr_q != LAST_IDX)) begin
            load_ptr_q <= load_ptr_q + 1'b1;
         end
      end
   end

   // Memory-mapped registers and the sticky error flag.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         gpio_q  <= '0;
         cycle_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (wr_en && gpio_sel) begin
            gpio_q <= bus.wdata_bus;
         end
         // A clear write wins over the running increment.
         if (wr_en && cyc_sel) begin
            cycle_q <= '0;
         end else if (run) begin
            cycle_q <= cycle_q + 32'd1;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   // RAM write port, shared by the loader (LOAD only) and the processor (RUN only).
   always_ff @(posedge clk) begin
      if (load_acc) begin
         mem[load_ptr_q] <= bus.load_data;
      end else if (ram_we) begin
         mem[ram_idx] <= bus.wdata_bus;
      end
   end

   // Zero-latency read mux; returns the pre-edge contents of whichever target is addressed.
   always_comb begin
      bus.rdata_bus = '0;
      if (rd_en) begin
         if (ram_sel) begin
            bus.rdata_bus = mem[ram_idx];
         end else if (gpio_sel) begin
            bus.rdata_bus = gpio_q;
         end else if (cyc_sel) begin
            bus.rdata_bus = cycle_q;
         end
      end
   end

   assign cpu_nreset   = cpu_nreset_q;
   assign gpio_out     = gpio_q;
   assign access_error = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed boot/MMIO/error tables plus randomized
// processor traffic checked against a behavioural model of the RAM and registers.
module tb_mem_responder;
   localparam int unsigned DEPTH         = 4096;
   localparam logic [23:0] GPIO_ADDR     = 24'hFFFFF0;
   localparam logic [23:0] CYCLE_ADDR    = 24'hFFFFF4;
   localparam int unsigned PROTECT_WORDS = 256;
`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
   localparam bit          PROT   = 1'b1;
   localparam logic [23:0] T_ADDR = 24'h000110;  // outside the protected region
`else
   localparam bit          PROT   = 1'b0;
   localparam logic [23:0] T_ADDR = 24'h000010;
`endif

   logic        clk = 1'b0;
   logic        nreset;
   logic        cpu_nreset;
   logic [31:0] gpio_out;
   logic        access_error;

   mem_responder_if bus ();

   mem_responder #(
      .DEPTH        (DEPTH),
      .ADDR_W       (12),
      .GPIO_ADDR    (GPIO_ADDR),
      .CYCLE_ADDR   (CYCLE_ADDR),
      .PROTECT_WORDS(PROTECT_WORDS)
   ) dut (
      .clk         (clk),
      .nreset      (nreset),
      .bus         (bus),
      .cpu_nreset  (cpu_nreset),
      .gpio_out    (gpio_out),
      .access_error(access_error)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model state
   logic [31:0] m_ram [DEPTH];
   logic [31:0] m_gpio;
   logic [31:0] m_cnt;
   logic        m_err;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } load_vec_t;

   typedef struct {
      logic [1:0]  ctrl;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [31:0] exp_gpio;
   } run_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bus(input logic [1:0] c, input logic [23:0] a, input logic [31:0] d);
      bus.control_bus = c;
      bus.address_bus = a;
      bus.wdata_bus   = d;
   endtask

   // One bus cycle with explicit expectations for rdata (this cycle) and access_error (pre-edge).
   task automatic probe(input string name, input logic [1:0] c, input logic [23:0] a,
                        input logic [31:0] d, input logic [31:0] exp_r, input logic exp_e);
      set_bus(c, a, d);
      @(negedge clk);
      check({name, " rdata"}, bus.rdata_bus, exp_r);
      check({name, " access_error"}, access_error, exp_e);
      step();
   endtask

   // Offer one loader word; it must be accepted (LOAD state).
   task automatic load_word(input logic [31:0] data, input logic last);
      bus.load_valid = 1'b1;
      bus.load_data  = data;
      bus.load_last  = last;
      @(negedge clk);
      check("load load_ready", bus.load_ready, 1'b1);
      check("load cpu_nreset", cpu_nreset, 1'b0);
      check("load rdata", bus.rdata_bus, 32'h0);
      step();
   endtask

   task automatic do_reset(input int cycles);
      nreset         = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.load_last  = 1'b0;
      set_bus(2'b00, 24'h0, 32'h0);
      repeat (cycles) step();
      @(negedge clk);
      check("reset cpu_nreset", cpu_nreset, 1'b0);
      check("reset load_ready", bus.load_ready, 1'b1);
      check("reset access_error", access_error, 1'b0);
      check("reset gpio_out", gpio_out, 32'h0);
      step();
      nreset = 1'b1;
   endtask

   // Model-checked RUN cycle: expectations derived from the address map rules.
   task automatic op(input logic [1:0] c, input logic [23:0] a, input logic [31:0] d);
      logic [31:0] exp_r;
      logic        is_ram, mapped, clr;
      is_ram = a < 24'(DEPTH);
      mapped = is_ram || (a == GPIO_ADDR) || (a == CYCLE_ADDR);
      exp_r  = 32'h0;
      if (c == 2'b10) begin
         if (is_ram) exp_r = m_ram[a[11:0]];
         else if (a == GPIO_ADDR) exp_r = m_gpio;
         else if (a == CYCLE_ADDR) exp_r = m_cnt;
      end
      set_bus(c, a, d);
      @(negedge clk);
      check($sformatf("op c=%b a=%h rdata", c, a), bus.rdata_bus, exp_r);
      check($sformatf("op c=%b a=%h gpio_out", c, a), gpio_out, m_gpio);
      check($sformatf("op c=%b a=%h access_error", c, a), access_error, m_err);
      check("op cpu_nreset", cpu_nreset, 1'b1);
      step();
      clr = 1'b0;
      if (c == 2'b11) m_err = 1'b1;
      if (c == 2'b10 && !mapped) m_err = 1'b1;
      if (c == 2'b01) begin
         if (!mapped) m_err = 1'b1;
         else if (is_ram) begin
            if (PROT && (a < 24'(PROTECT_WORDS))) m_err = 1'b1;
            else m_ram[a[11:0]] = d;
         end else if (a == GPIO_ADDR) m_gpio = d;
         else clr = 1'b1;
      end
      m_cnt = clr ? 32'h0 : m_cnt + 32'd1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      load_vec_t   boot_tbl [4];
      run_vec_t    run_tbl [18];
      logic [1:0]  c;
      logic [23:0] a;
      logic [31:0] d;
      int          r;

      boot_tbl[0] = '{32'h11, 1'b0};
      boot_tbl[1] = '{32'h22, 1'b0};
      boot_tbl[2] = '{32'h33, 1'b0};
      boot_tbl[3] = '{32'h44, 1'b1};

      run_tbl[0]  = '{2'b10, 24'h000000, 32'h0, 32'h11, 32'h0};
      run_tbl[1]  = '{2'b10, 24'h000001, 32'h0, 32'h22, 32'h0};
      run_tbl[2]  = '{2'b10, 24'h000002, 32'h0, 32'h33, 32'h0};
      run_tbl[3]  = '{2'b10, 24'h000003, 32'h0, 32'h44, 32'h0};
      run_tbl[4]  = '{2'b01, T_ADDR, 32'hDEADBEEF, 32'h0, 32'h0};
      run_tbl[5]  = '{2'b10, T_ADDR, 32'h0, 32'hDEADBEEF, 32'h0};
      run_tbl[6]  = '{2'b01, GPIO_ADDR, 32'hA5A5A5A5, 32'h0, 32'h0};
      run_tbl[7]  = '{2'b00, GPIO_ADDR, 32'h0, 32'h0, 32'hA5A5A5A5};
      run_tbl[8]  = '{2'b10, GPIO_ADDR, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5};
      run_tbl[9]  = '{2'b01, CYCLE_ADDR, 32'h12345, 32'h0, 32'hA5A5A5A5};
      run_tbl[10] = '{2'b00, 24'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
      run_tbl[11] = '{2'b00, 24'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
      run_tbl[12] = '{2'b00, 24'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
      run_tbl[13] = '{2'b00, 24'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
      run_tbl[14] = '{2'b10, CYCLE_ADDR, 32'h0, 32'd4, 32'hA5A5A5A5};
      run_tbl[15] = '{2'b10, CYCLE_ADDR, 32'h0, 32'd5, 32'hA5A5A5A5};
      run_tbl[16] = '{2'b01, T_ADDR, 32'hCAFEF00D, 32'h0, 32'hA5A5A5A5};
      run_tbl[17] = '{2'b10, T_ADDR, 32'h0, 32'hCAFEF00D, 32'hA5A5A5A5};

      // Boot: reset, stream four words, RELEASE, RUN
      do_reset(3);
      for (int i = 0; i < 4; i++) load_word(boot_tbl[i].data, boot_tbl[i].last);
      bus.load_data = 32'h99;  // offered in RELEASE, must not be taken
      @(negedge clk);
      check("release load_ready", bus.load_ready, 1'b0);
      check("release cpu_nreset", cpu_nreset, 1'b0);
      step();
      bus.load_valid = 1'b0;
      @(negedge clk);
      check("run cpu_nreset", cpu_nreset, 1'b1);
      check("run load_ready", bus.load_ready, 1'b0);
      step();

      for (int i = 0; i < 18; i++) begin
         set_bus(run_tbl[i].ctrl, run_tbl[i].addr, run_tbl[i].wdata);
         @(negedge clk);
         check($sformatf("vec%0d rdata", i), bus.rdata_bus, run_tbl[i].exp_rdata);
         check($sformatf("vec%0d gpio_out", i), gpio_out, run_tbl[i].exp_gpio);
         check($sformatf("vec%0d access_error", i), access_error, 1'b0);
         step();
      end

      // Unmapped read: zero data, sticky error
      probe("unmapped read", 2'b10, 24'h800000, 32'h0, 32'h0, 1'b0);
      probe("after unmapped", 2'b00, 24'h0, 32'h0, 32'h0, 1'b1);
      probe("sticky", 2'b10, 24'h000000, 32'h0, 32'h11, 1'b1);

      // Reset mid-run: back to LOAD; bus is ignored while loading
      do_reset(2);
      for (int i = 0; i < 8; i++) begin
         set_bus((i == 0) ? 2'b11 : 2'b10, 24'h800000, 32'h0);
         load_word(32'h70 + 32'(i), i == 7);
      end
      bus.load_valid = 1'b0;
      set_bus(2'b00, 24'h0, 32'h0);
      step();
      probe("protect wr5", 2'b01, 24'h000005, 32'hBEEF0005, 32'h0, 1'b0);
      probe("protect rd5", 2'b10, 24'h000005, 32'h0, PROT ? 32'h75 : 32'hBEEF0005, PROT);
      probe("wr boundary", 2'b01, 24'(PROTECT_WORDS), 32'h600D0100, 32'h0, PROT);
      probe("rd boundary", 2'b10, 24'(PROTECT_WORDS), 32'h0, 32'h600D0100, PROT);
      probe("ram kept", 2'b10, T_ADDR, 32'h0, 32'hCAFEF00D, PROT);
      probe("illegal ctrl", 2'b11, 24'h000000, 32'h0, 32'h0, PROT);
      probe("after illegal", 2'b00, 24'h0, 32'h0, 32'h0, 1'b1);

      // Load overflow: DEPTH words without load_last
      do_reset(2);
      for (int i = 0; i < DEPTH; i++) begin
         load_word(32'hA000_0000 | 32'(i), 1'b0);
         m_ram[i] = 32'hA000_0000 | 32'(i);
      end
      bus.load_data = 32'hBADBAD00;
      @(negedge clk);
      check("overflow load_ready", bus.load_ready, 1'b0);
      check("overflow cpu_nreset", cpu_nreset, 1'b0);
      step();
      bus.load_valid = 1'b0;
      m_gpio = 32'h0;
      m_cnt  = 32'h0;
      m_err  = 1'b0;
      op(2'b10, 24'h000000, 32'h0);
      op(2'b10, 24'(DEPTH - 1), 32'h0);

      // Randomized traffic in three RUN sessions
      for (int s = 0; s < 3; s++) begin
         for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 15);
            if (r <= 10) a = 24'($urandom_range(0, DEPTH - 1));
            else if (r <= 12) a = GPIO_ADDR;
            else if (r <= 14) a = CYCLE_ADDR;
            else a = 24'($urandom_range(DEPTH, 32'hFFFFEF));
            r = $urandom_range(0, 31);
            if (r == 0) c = 2'b11;
            else if (r < 14) c = 2'b10;
            else if (r < 26) c = 2'b01;
            else c = 2'b00;
            d = $urandom;
            op(c, a, d);
         end
         do_reset(2);
         d = $urandom;
         load_word(d, 1'b1);
         m_ram[0] = d;
         bus.load_valid = 1'b0;
         step();
         m_gpio = 32'h0;
         m_cnt  = 32'h0;
         m_err  = 1'b0;
      end
      op(2'b10, 24'h000000, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
